// File: rtl/lifo_fifo_buf_if.sv
// Handshake/data bundle between a producer/consumer and the lifo_fifo_buf storage.
interface lifo_fifo_buf_if #(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 10
);
  logic                         write;
  logic [DATA_W-1:0]            datain;
  logic                         read;
  logic                         mode_load;
  logic                         mode_in;
  logic                         clear_err;
  logic [DATA_W-1:0]            dataout;
  logic                         val;
  logic                         full;
  logic                         empty;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         mode;
  logic                         ovf;
  logic                         udf;

  modport master (
    output write, datain, read, mode_load, mode_in, clear_err,
    input  dataout, val, full, empty, count, mode, ovf, udf
  );

  modport slave (
    input  write, datain, read, mode_load, mode_in, clear_err,
    output dataout, val, full, empty, count, mode, ovf, udf
  );
endinterface

// File: rtl/lifo_fifo_buf.sv
// Run-time selectable LIFO/FIFO buffer with occupancy, sticky error flags
// and defined simultaneous read/write behaviour in both orders.
module lifo_fifo_buf #(
  parameter int       DEPTH    = 6,
  parameter int       DATA_W   = 10,
  parameter bit       MODE_RST = 1'b1
) (
  input logic               clk,
  input logic               reset,
  lifo_fifo_buf_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CW-1:0]     count_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic              mode_r;
  logic [DATA_W-1:0] dataout_r;
  logic              val_r;
  logic              ovf_r;
  logic              udf_r;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              pass_s;
  logic              swap_s;
  logic              ovf_set_s;
  logic              udf_set_s;
  logic              mode_ok_s;
  logic              mem_we_s;
  logic [PW-1:0]     wr_addr_s;
  logic [PW-1:0]     rd_addr_s;

  // FIFO pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == CW'(0));

  // Decode the per-cycle operation and the storage addresses it touches.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    pass_s    = 1'b0;
    swap_s    = 1'b0;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    case ({bus.write, bus.read})
      2'b10: begin
        push_s    = ~full_s;
        ovf_set_s = full_s;
      end
      2'b01: begin
        pop_s     = ~empty_s;
        udf_set_s = empty_s;
      end
      2'b11: begin
        // LIFO, or an empty FIFO, hands the incoming word straight through.
        if (mode_r || empty_s) begin
          pass_s = 1'b1;
        end else begin
          swap_s = 1'b1;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
    mode_ok_s = bus.mode_load & empty_s & ~bus.read & ~bus.write;
    mem_we_s  = push_s | swap_s;
    if (mode_r) begin
      wr_addr_s = PW'(count_r);
      rd_addr_s = PW'(count_r - CW'(1));
    end else begin
      wr_addr_s = wr_ptr_r;
      rd_addr_s = rd_ptr_r;
    end
  end

  // Storage array; contents are not reset, occupancy tracking makes them don't-care.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_addr_s] <= bus.datain;
    end
  end

  // Control state, registered outputs and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r   <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      mode_r    <= MODE_RST;
      dataout_r <= '0;
      val_r     <= 1'b0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else begin
      val_r <= pop_s | pass_s | swap_s;

      if (pop_s || swap_s) begin
        dataout_r <= mem_r[rd_addr_s];
      end else if (pass_s) begin
        dataout_r <= bus.datain;
      end else begin
        dataout_r <= dataout_r;
      end

      if (push_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end

      if (mode_ok_s) begin
        mode_r   <= bus.mode_in;
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else if (!mode_r) begin
        if (push_s || swap_s) begin
          wr_ptr_r <= ptr_inc(wr_ptr_r);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s || swap_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
      end else begin
        wr_ptr_r <= wr_ptr_r;
        rd_ptr_r <= rd_ptr_r;
      end

      // A fresh error in the same cycle as clear_err keeps the flag set.
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (bus.clear_err) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end

      if (udf_set_s) begin
        udf_r <= 1'b1;
      end else if (bus.clear_err) begin
        udf_r <= 1'b0;
      end else begin
        udf_r <= udf_r;
      end
    end
  end

  assign bus.dataout = dataout_r;
  assign bus.val     = val_r;
  assign bus.full    = full_s;
  assign bus.empty   = empty_s;
  assign bus.count   = count_r;
  assign bus.mode    = mode_r;
  assign bus.ovf     = ovf_r;
  assign bus.udf     = udf_r;
endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Directed bench for lifo_fifo_buf with a scoreboard queue of expected pops.
module tb_lifo_fifo_buf;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [9:0] exp_q[$];
  logic [9:0] exp_d;

  lifo_fifo_buf_if #(.DEPTH(6), .DATA_W(10)) bus ();

  lifo_fifo_buf #(.DEPTH(6), .DATA_W(10), .MODE_RST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then check val/dataout against the scoreboard.
  task automatic step(input logic w, input logic r, input logic [9:0] d,
                      input logic ml, input logic mi, input logic ce,
                      input logic ev, input logic [9:0] ed);
    bus.write     = w;
    bus.read      = r;
    bus.datain    = d;
    bus.mode_load = ml;
    bus.mode_in   = mi;
    bus.clear_err = ce;
    if (ev) exp_q.push_back(ed);
    @(posedge clk);
    #1;
    chk("val", {31'd0, bus.val}, {31'd0, ev});
    if (bus.val) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_val", 32'd1, 32'd0);
      end else begin
        exp_d = exp_q.pop_front();
        chk("dataout", {22'd0, bus.dataout}, {22'd0, exp_d});
      end
    end
    bus.write = 1'b0; bus.read = 1'b0; bus.mode_load = 1'b0; bus.clear_err = 1'b0;
  endtask

  task automatic push(input logic [9:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic pop(input logic [9:0] e);
    step(1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, e);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] c, input logic e,
                           input logic f, input logic o, input logic u, input logic m);
    chk({tag, "_count"}, {29'd0, bus.count}, {29'd0, c});
    chk({tag, "_empty"}, {31'd0, bus.empty}, {31'd0, e});
    chk({tag, "_full"},  {31'd0, bus.full},  {31'd0, f});
    chk({tag, "_ovf"},   {31'd0, bus.ovf},   {31'd0, o});
    chk({tag, "_udf"},   {31'd0, bus.udf},   {31'd0, u});
    chk({tag, "_mode"},  {31'd0, bus.mode},  {31'd0, m});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.write = 1'b0; bus.read = 1'b0; bus.datain = 10'd0;
    bus.mode_load = 1'b0; bus.mode_in = 1'b0; bus.clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_val", {31'd0, bus.val}, 32'd0);
    chk("rst_dout", {22'd0, bus.dataout}, 32'd0);
    reset = 1'b0;

    // 1. LIFO order reversal
    push(10'd1); push(10'd2); push(10'd3);
    chk_state("lifo_fill", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop(10'd3); pop(10'd2); pop(10'd1);
    chk_state("lifo_drain", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2. Switch to FIFO, order kept, pointers wrap past DEPTH-1
    step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    chk("mode_fifo", {31'd0, bus.mode}, 32'd0);
    push(10'd10); push(10'd11); push(10'd12);
    pop(10'd10); pop(10'd11); pop(10'd12);
    for (int i = 0; i < 4; i++) begin
      push(10'd20 + 10'(i));
      pop(10'd20 + 10'(i));
    end
    chk_state("fifo_wrap", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3/4. Fill, overflow, swap while full, drain, underflow, clear
    for (int i = 1; i <= 6; i++) push(10'(i));
    chk_state("fifo_full", 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(10'h3FF);
    chk_state("ovf", 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'd7, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1);
    chk("swap_count", {29'd0, bus.count}, 32'd6);
    for (int i = 2; i <= 7; i++) pop(10'(i));
    step(1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    chk_state("udf", 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("udf_hold", {22'd0, bus.dataout}, 32'd7);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    chk_state("clr", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    chk("udf_wins", {31'd0, bus.udf}, 32'd1);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    chk("udf_clr2", {31'd0, bus.udf}, 32'd0);
    step(1'b1, 1'b1, 10'h055, 1'b0, 1'b0, 1'b0, 1'b1, 10'h055);
    chk("fifo_pass_count", {29'd0, bus.count}, 32'd0);

    // 5. LIFO simultaneous read/write passes datain through
    step(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
    chk("mode_lifo", {31'd0, bus.mode}, 32'd1);
    push(10'd5);
    step(1'b1, 1'b1, 10'd9, 1'b0, 1'b0, 1'b0, 1'b1, 10'd9);
    chk("lifo_pass_count", {29'd0, bus.count}, 32'd1);
    pop(10'd5);

    // 6. Ignored mode loads, then asynchronous reset between edges
    push(10'd1);
    step(1'b1, 1'b0, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    chk_state("ml_busy", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    chk("ml_nonempty", {31'd0, bus.mode}, 32'd1);
    pop(10'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", {29'd0, bus.count}, 32'd0);
    chk("arst_val", {31'd0, bus.val}, 32'd0);
    chk("arst_dout", {22'd0, bus.dataout}, 32'd0);
    chk("arst_mode", {31'd0, bus.mode}, 32'd1);
    chk("arst_empty", {31'd0, bus.empty}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("leftover_q", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
